cic_decim_fifo: RTL and testbench
=================================

CIC_DECIM_FIFO -- requirements
Module: cic_decim_fifo

Interface
REQ-001 Parameter I_WIDTH, default 2, signed two's-complement input sample width.
REQ-002 Parameter ORDER, default 7, number of integrator stages and number of comb stages.
REQ-003 Parameter DECIMATION_BITS, default 18; decimation ratio R = 2^DECIMATION_BITS.
REQ-004 Parameter O_WIDTH, default 16, width of the samples stored in the FIFO.
REQ-005 Parameter FIFO_ADDR_WIDTH, default 6; FIFO depth = 2^FIFO_ADDR_WIDTH.
REQ-006 Parameter OVERWRITE_OLD, default 1; when 1, a write to a full FIFO discards the oldest entry.
REQ-007 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 Port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Port i_en, input, 1 bit: clock enable for all state.
REQ-010 Port i_data, input, I_WIDTH bits: signed input sample.
REQ-011 Port i_rd, input, 1 bit: FIFO pop request.
REQ-012 Port o_clk, output, 1 bit: decimated clock, equal to the MSB of the decimation counter.
REQ-013 Port o_data, output, O_WIDTH bits: registered FIFO read data.
REQ-014 Port o_empty, output, 1 bit: FIFO empty flag. Port o_full, output, 1 bit: FIFO full flag.
REQ-015 Port o_count, output, FIFO_ADDR_WIDTH+1 bits: number of FIFO entries.

Function
REQ-016 Internal width W = I_WIDTH + ORDER*DECIMATION_BITS; all integrator and comb arithmetic is W-bit two's complement with modulo wrap and no saturation.
REQ-017 All state, including the counter, integrators, combs, write strobe and FIFO, holds its value when i_en = 0.
REQ-018 Counter: a DECIMATION_BITS-bit up-counter that increments by 1 on each enabled edge and wraps from 2^DECIMATION_BITS-1 to 0.
REQ-019 Integrator 1 adds sign-extended i_data on each enabled edge.
REQ-020 Integrator k (k > 1) adds the pre-edge register value of integrator k-1 on each enabled edge.
REQ-021 Decimation event E: an enabled edge at which the counter equals all-ones.
REQ-022 At E, the comb chain takes the pre-edge value of the last integrator.
REQ-023 Each comb stage computes y = x - x_prev, where x_prev is that stage's input captured at the previous E; differential delay is 1.
REQ-024 The comb stages form a combinational chain; the chain result is registered at E.
REQ-025 At E, all comb delay registers update.
REQ-026 A write strobe is registered at E, so it is 1 for the enabled edge following E.
REQ-027 On the enabled edge after E, the FIFO writes comb_out[W-1 -: O_WIDTH], the top O_WIDTH bits of the comb output.
REQ-028 FIFO read: when i_rd = 1 and o_empty = 0, o_data <= mem[rd_ptr] and rd_ptr advances, so read latency is 1 cycle.
REQ-029 When i_rd = 1 and the FIFO is empty, the read is ignored and o_data holds.
REQ-030 FIFO write to a non-full FIFO: data is stored at wr_ptr and wr_ptr advances.
REQ-031 FIFO write to a full FIFO with OVERWRITE_OLD = 1: the write is stored and both pointers advance; the count stays at depth.
REQ-032 FIFO write to a full FIFO with OVERWRITE_OLD = 0: the write is dropped.
REQ-033 Simultaneous read and write when the FIFO is not empty: both occur and the count is unchanged.
REQ-034 Simultaneous read and write when the FIFO is empty: only the write occurs.
REQ-035 Simultaneous read and write when the FIFO is full: a normal read plus a normal write; there is no overwrite.
REQ-036 Pointers wrap modulo the depth.
REQ-037 o_empty = (count == 0); o_full = (count == depth); both are derived from registered state.

Reset
REQ-038 i_rst = 0 asynchronously clears the counter, all integrators, comb delays, the comb output, the write strobe, the FIFO pointers and the count, and o_data.
REQ-039 Outputs during reset: o_clk = 0, o_data = 0, o_empty = 1, o_full = 0, o_count = 0.
REQ-040 FIFO memory contents are not reset.
REQ-041 Reset asserted mid-frame discards any partial decimation and all queued samples.
REQ-042 After reset is released, the first E occurs on the 2^DECIMATION_BITS-th enabled edge.

Verification
Use I_WIDTH = 2, ORDER = 1, DECIMATION_BITS = 2, O_WIDTH = 4, FIFO_ADDR_WIDTH = 2 unless stated otherwise.
REQ-043 Constant i_data = +1 (01), i_en = 1 -> the FIFO receives 3, then 4, 4, ...; o_clk has period 4 and is high for 2 cycles.
REQ-044 Constant i_data = -1 (11) -> the FIFO receives -3 (1101), then steady -4 (1100).
REQ-045 i_en toggled 0/1 every other cycle -> the output sequence is identical to the REQ-043 sequence, taking twice the cycles.
REQ-046 Six samples written with no reads, OVERWRITE_OLD = 1 -> o_full = 1, o_count = 4, and pops return samples 3, 4, 5, 6 in order.
REQ-047 Pop while empty -> o_data unchanged, o_count = 0; read and write on the same edge with count = 2 -> count stays 2.
REQ-048 i_rst pulsed low mid-operation -> outputs immediately read 0/empty without waiting for a clock edge, and the first sample after release is again 3.

Source files
------------

// File: rtl/cic_decim_fifo_if.sv
// Sample/FIFO bundle between a CIC decimator and its consumer.
// The master drives the sample stream and pop requests; the slave returns FIFO status and data.
interface cic_decim_fifo_if #(
   parameter int unsigned I_WIDTH         = 2,
   parameter int unsigned O_WIDTH         = 16,
   parameter int unsigned FIFO_ADDR_WIDTH = 6
) ();
   logic                       i_en;
   logic [I_WIDTH-1:0]         i_data;
   logic                       i_rd;
   logic                       o_clk;
   logic [O_WIDTH-1:0]         o_data;
   logic                       o_empty;
   logic                       o_full;
   logic [FIFO_ADDR_WIDTH:0]   o_count;

   modport master (
      output i_en, i_data, i_rd,
      input  o_clk, o_data, o_empty, o_full, o_count
   );

   modport slave (
      input  i_en, i_data, i_rd,
      output o_clk, o_data, o_empty, o_full, o_count
   );
endinterface

// File: rtl/cic_decim_fifo.sv
// CIC decimator (ORDER integrators, ORDER combs, R = 2^DECIMATION_BITS) feeding a small
// output FIFO with optional overwrite-oldest behaviour when full.
module cic_decim_fifo #(
   parameter int unsigned I_WIDTH         = 2,
   parameter int unsigned ORDER           = 7,
   parameter int unsigned DECIMATION_BITS = 18,
   parameter int unsigned O_WIDTH         = 16,
   parameter int unsigned FIFO_ADDR_WIDTH = 6,
   parameter bit          OVERWRITE_OLD   = 1'b1
) (
   input logic            i_clk,
   input logic            i_rst,
   cic_decim_fifo_if.slave bus
);
   localparam int unsigned W     = I_WIDTH + ORDER * DECIMATION_BITS;
   localparam int unsigned DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;

   logic [DECIMATION_BITS-1:0] cnt_q, cnt_d;
   logic [W-1:0]               integ_q [ORDER];
   logic [W-1:0]               integ_d [ORDER];
   logic [W-1:0]               dly_q   [ORDER];
   logic [W-1:0]               dly_d   [ORDER];
   logic [W-1:0]               comb_x  [ORDER+1];
   logic [O_WIDTH-1:0]         comb_q, comb_d;
   logic                       wr_q, wr_d;
   logic [O_WIDTH-1:0]         mem_q [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic [O_WIDTH-1:0]         rdata_q, rdata_d;
   logic [W-1:0]               din_ext;
   logic                       dec_evt, empty, full, do_rd, do_wr, mem_we;

   assign din_ext = {{(W - I_WIDTH){bus.i_data[I_WIDTH-1]}}, bus.i_data};
   assign dec_evt = bus.i_en && (cnt_q == '1);
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));

   always_comb begin
      cnt_d   = cnt_q;
      integ_d = integ_q;
      dly_d   = dly_q;
      comb_d  = comb_q;
      wr_d    = wr_q;
      comb_x[0] = integ_q[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
         comb_x[k+1] = comb_x[k] - dly_q[k];
      end
      if (bus.i_en) begin
         cnt_d      = cnt_q + DECIMATION_BITS'(1);
         integ_d[0] = integ_q[0] + din_ext;
         // Each stage accumulates the pre-edge value of the stage before it.
         for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
         end
         wr_d = dec_evt;
         if (dec_evt) begin
            comb_d = comb_x[ORDER][W-1 -: O_WIDTH];
            for (int k = 0; k < ORDER; k++) begin
               dly_d[k] = comb_x[k];
            end
         end
      end
   end

   always_comb begin
      do_rd    = bus.i_en && bus.i_rd && !empty;
      do_wr    = bus.i_en && wr_q;
      mem_we   = do_wr && (!full || do_rd || OVERWRITE_OLD);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rdata_d  = rdata_q;
      count_d  = count_q;
      if (mem_we) wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
         rdata_d  = mem_q[rd_ptr_q];
      end else if (mem_we && full) begin
         // Overwrite: the oldest entry is dropped, so the read side skips past it.
         rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
      if (do_rd && !mem_we)            count_d = count_q - CW'(1);
      else if (!do_rd && mem_we && !full) count_d = count_q + CW'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q    <= '0;
         comb_q   <= '0;
         wr_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         comb_q   <= comb_d;
         wr_q     <= wr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= integ_d[k];
            dly_q[k]   <= dly_d[k];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= comb_q;
   end

   assign bus.o_clk   = cnt_q[DECIMATION_BITS-1];
   assign bus.o_data  = rdata_q;
   assign bus.o_empty = empty;
   assign bus.o_full  = full;
   assign bus.o_count = count_q;
endmodule

// File: tb/tb_cic_decim_fifo.sv
// Directed bench for cic_decim_fifo: first-order CIC with R = 4 and a 4-deep FIFO, built
// twice so overwrite-oldest and drop-new behaviour on a full FIFO can be compared.
module tb_cic_decim_fifo;
   localparam int unsigned IW  = 2;
   localparam int unsigned OW  = 4;
   localparam int unsigned FAW = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          en    = 1'b0;
   logic          rd    = 1'b0;
   logic [IW-1:0] din   = '0;
   int            n_checks = 0;
   int            n_errors = 0;

   cic_decim_fifo_if #(.I_WIDTH(IW), .O_WIDTH(OW), .FIFO_ADDR_WIDTH(FAW)) bus_ow ();
   cic_decim_fifo_if #(.I_WIDTH(IW), .O_WIDTH(OW), .FIFO_ADDR_WIDTH(FAW)) bus_dr ();

   assign bus_ow.i_en   = en;
   assign bus_ow.i_rd   = rd;
   assign bus_ow.i_data = din;
   assign bus_dr.i_en   = en;
   assign bus_dr.i_rd   = rd;
   assign bus_dr.i_data = din;

   cic_decim_fifo #(
      .I_WIDTH(IW), .ORDER(1), .DECIMATION_BITS(2), .O_WIDTH(OW),
      .FIFO_ADDR_WIDTH(FAW), .OVERWRITE_OLD(1'b1)
   ) u_dut_ow (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus_ow)
   );

   cic_decim_fifo #(
      .I_WIDTH(IW), .ORDER(1), .DECIMATION_BITS(2), .O_WIDTH(OW),
      .FIFO_ADDR_WIDTH(FAW), .OVERWRITE_OLD(1'b0)
   ) u_dut_dr (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus_dr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pop(input string tag, input logic [OW-1:0] exp);
      rd = 1'b1;
      step();
      rd = 1'b0;
      check(tag, 32'(bus_ow.o_data), 32'(exp));
   endtask

   // Asserts reset and checks outputs settle without any clock edge, then releases it.
   task automatic reset_check(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_oclk"},  32'(bus_ow.o_clk),   32'd0);
      check({tag, "_odata"}, 32'(bus_ow.o_data),  32'd0);
      check({tag, "_empty"}, 32'(bus_ow.o_empty), 32'd1);
      check({tag, "_full"},  32'(bus_ow.o_full),  32'd0);
      check({tag, "_count"}, 32'(bus_ow.o_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [IW-1:0] vals [8];
      logic [OW-1:0] exp_ow [4];
      logic [OW-1:0] exp_dr [4];
      vals   = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
      exp_ow = '{4'hC, 4'h4, 4'h8, 4'h0};
      exp_dr = '{4'h3, 4'h0, 4'hC, 4'h4};

      #1;
      reset_check("rst0");

      // Constant +1: samples 3, 4, 4 ...; o_clk low, high, high, low
      en  = 1'b1;
      din = 2'b01;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("oclk", 32'(bus_ow.o_clk), 32'((k >= 2 && k < 4) ? 1 : 0));
      end
      check("first_e_cnt", 32'(bus_ow.o_count), 32'd0);
      step();
      check("first_wr_cnt", 32'(bus_ow.o_count), 32'd1);
      check("first_wr_empty", 32'(bus_ow.o_empty), 32'd0);
      run(4);
      check("two_cnt", 32'(bus_ow.o_count), 32'd2);
      run(3);
      pop("rdwr_data", 4'h3);
      check("rdwr_cnt", 32'(bus_ow.o_count), 32'd2);
      pop("pos_s2", 4'h4);
      pop("pos_s3", 4'h4);
      check("drain_empty", 32'(bus_ow.o_empty), 32'd1);
      pop("empty_pop_hold", 4'h4);
      check("empty_pop_cnt", 32'(bus_ow.o_count), 32'd0);
      run(2);
      check("pre_rst_cnt", 32'(bus_ow.o_count), 32'd1);

      // Mid-operation reset, then constant -1: samples -3, -4, -4
      din = 2'b11;
      reset_check("rst1");
      run(13);
      check("neg_cnt", 32'(bus_ow.o_count), 32'd3);
      pop("neg_s1", 4'hD);
      pop("neg_s2", 4'hC);
      pop("neg_s3", 4'hC);

      // Enable toggling every other cycle: same sequence, twice the cycles
      din = 2'b01;
      reset_check("rst2");
      for (int i = 0; i < 26; i++) begin
         en = (i % 2 == 1);
         step();
      end
      en = 1'b1;
      check("tog_cnt", 32'(bus_ow.o_count), 32'd3);
      pop("tog_s1", 4'h3);
      pop("tog_s2", 4'h4);
      pop("tog_s3", 4'h4);

      // Six distinct samples (3, 0, C, 4, 8, 0) into a 4-deep FIFO with no reads
      reset_check("rst3");
      for (int e = 1; e <= 25; e++) begin
         din = vals[e / 4];
         step();
      end
      din = 2'b00;
      check("ow_full",  32'(bus_ow.o_full),  32'd1);
      check("ow_count", 32'(bus_ow.o_count), 32'd4);
      check("ow_odata", 32'(bus_ow.o_data),  32'd0);
      check("dr_full",  32'(bus_dr.o_full),  32'd1);
      check("dr_count", 32'(bus_dr.o_count), 32'd4);
      rd = 1'b1;
      for (int j = 0; j < 4; j++) begin
         step();
         check($sformatf("ow_pop%0d", j), 32'(bus_ow.o_data), 32'(exp_ow[j]));
         check($sformatf("dr_pop%0d", j), 32'(bus_dr.o_data), 32'(exp_dr[j]));
      end
      rd = 1'b0;

      // Mid-frame reset discards the partial frame; first sample after release is 3 again
      din = 2'b01;
      reset_check("rst4");
      run(4);
      check("post_rst_lat", 32'(bus_ow.o_count), 32'd0);
      step();
      check("post_rst_cnt", 32'(bus_ow.o_count), 32'd1);
      pop("post_rst_s1", 4'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
